// File: rtl/pe_array_sched.sv
// Tile sequencer for the unary systolic PE array: weight load, skewed compute
// wavefront, output drain, done. Every array control output is registered.
module pe_array_sched #(
  parameter int unsigned ROW_NUM        = 8,
  parameter int unsigned COLUMN_NUM     = 8,
  parameter int unsigned M_END_BITWIDTH = 8,
  parameter int unsigned LEN_BITWIDTH   = 8,
  parameter int unsigned CNT_BITWIDTH   = 20
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 cfg_valid,
  output logic                                 cfg_ready,
  input  logic [M_END_BITWIDTH-1:0]            cfg_m_end,
  input  logic [LEN_BITWIDTH-1:0]              cfg_stream_len,
  input  logic                                 abort,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 out_valid,
  output logic [$clog2(ROW_NUM)-1:0]           out_row,
  output logic [ROW_NUM*COLUMN_NUM-1:0]        vector_weight_reg_en,
  output logic [ROW_NUM*COLUMN_NUM-1:0]        vector_weight_reg_r0w1,
  output logic [ROW_NUM*COLUMN_NUM-1:0]        vector_input_reg_en,
  output logic [ROW_NUM*COLUMN_NUM-1:0]        vector_input_reg_r0w1,
  output logic [ROW_NUM*COLUMN_NUM-1:0]        vector_rand_num_reg_en,
  output logic [ROW_NUM*COLUMN_NUM-1:0]        vector_rand_num_reg_r0w1,
  output logic [ROW_NUM*COLUMN_NUM-1:0]        vector_output_num_reg_en,
  output logic [ROW_NUM*COLUMN_NUM-1:0]        vector_output_num_reg_r0w1,
  output logic [ROW_NUM*M_END_BITWIDTH-1:0]    M_end
);

  localparam int unsigned PE_NUM   = ROW_NUM * COLUMN_NUM;
  localparam int unsigned ROW_W    = $clog2(ROW_NUM);
  localparam int unsigned DIAG_NUM = ROW_NUM + COLUMN_NUM - 1;

  typedef enum logic [2:0] {IDLE, WLOAD, COMPUTE, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [CNT_BITWIDTH-1:0] cnt, cnt_nxt, ml;
  logic                    accept_c;
  logic [DIAG_NUM-1:0]     diag_act;
  logic [PE_NUM-1:0]       pe_act;

  // Phase sequencing; the counter reloads to 0 on the last cycle of each phase.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    accept_c  = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_valid) begin
          accept_c  = 1'b1;
          state_nxt = (cfg_m_end == '0 || cfg_stream_len == '0) ? DONE : WLOAD;
        end
      end
      WLOAD: begin
        if (cnt == CNT_BITWIDTH'(ROW_NUM - 1)) state_nxt = COMPUTE;
        else cnt_nxt = cnt + CNT_BITWIDTH'(1);
      end
      COMPUTE: begin
        if (cnt == ml + CNT_BITWIDTH'(ROW_NUM + COLUMN_NUM - 3)) state_nxt = DRAIN;
        else cnt_nxt = cnt + CNT_BITWIDTH'(1);
      end
      DRAIN: begin
        if (cnt == CNT_BITWIDTH'(ROW_NUM - 1)) state_nxt = DONE;
        else cnt_nxt = cnt + CNT_BITWIDTH'(1);
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  // PEs on the same anti-diagonal r+c share one wavefront window [d, d+M*L).
  always_comb begin
    diag_act = '0;
    pe_act   = '0;
    for (int unsigned d = 0; d < DIAG_NUM; d++) begin
      diag_act[d] = (cnt_nxt >= CNT_BITWIDTH'(d)) &&
                    ((cnt_nxt - CNT_BITWIDTH'(d)) < ml);
    end
    for (int unsigned r = 0; r < ROW_NUM; r++) begin
      for (int unsigned c = 0; c < COLUMN_NUM; c++) begin
        pe_act[r*COLUMN_NUM + c] = diag_act[r + c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state                      <= IDLE;
      cnt                        <= '0;
      ml                         <= '0;
      cfg_ready                  <= 1'b1;
      busy                       <= 1'b0;
      done                       <= 1'b0;
      out_valid                  <= 1'b0;
      out_row                    <= '0;
      vector_weight_reg_en       <= '0;
      vector_weight_reg_r0w1     <= '0;
      vector_input_reg_en        <= '0;
      vector_input_reg_r0w1      <= '0;
      vector_rand_num_reg_en     <= '0;
      vector_rand_num_reg_r0w1   <= '0;
      vector_output_num_reg_en   <= '0;
      vector_output_num_reg_r0w1 <= '0;
      M_end                      <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept_c) begin
        ml    <= CNT_BITWIDTH'(cfg_m_end) * CNT_BITWIDTH'(cfg_stream_len);
        M_end <= {ROW_NUM{cfg_m_end}};
      end
      cfg_ready <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
      out_valid <= (state_nxt == DRAIN);
      out_row   <= (state_nxt == DRAIN) ? cnt_nxt[ROW_W-1:0] : '0;
      vector_weight_reg_en     <= {PE_NUM{state_nxt == WLOAD}};
      vector_weight_reg_r0w1   <= {PE_NUM{state_nxt == WLOAD}};
      vector_input_reg_en      <= (state_nxt == COMPUTE) ? pe_act : '0;
      vector_input_reg_r0w1    <= (state_nxt == COMPUTE) ? pe_act : '0;
      vector_rand_num_reg_en   <= (state_nxt == COMPUTE) ? pe_act : '0;
      vector_rand_num_reg_r0w1 <= (state_nxt == COMPUTE) ? pe_act : '0;
      // Drain shifts partial sums toward row 0, hence r0w1 low.
      vector_output_num_reg_en   <= (state_nxt == COMPUTE) ? pe_act :
                                    (state_nxt == DRAIN)   ? '1 : '0;
      vector_output_num_reg_r0w1 <= (state_nxt == COMPUTE) ? pe_act : '0;
    end
  end

endmodule

// File: tb/tb_pe_array_sched.sv
// Bench for pe_array_sched on a 4x4 array: offset-based phase model, directed
// scenarios with hand-computed timing, then randomized traffic.
module tb_pe_array_sched;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int PE = R * C;
  localparam int PH_IDLE = 0, PH_WLOAD = 1, PH_COMP = 2, PH_DRAIN = 3, PH_DONE = 4;

  logic clk = 1'b0;
  logic resetn, cfg_valid, cfg_ready, abort, busy, done, out_valid;
  logic [7:0] cfg_m_end, cfg_stream_len;
  logic [1:0] out_row;
  logic [PE-1:0] w_en, w_rw, i_en, i_rw, r_en, r_rw, o_en, o_rw;
  logic [R*8-1:0] M_end;

  pe_array_sched #(.ROW_NUM(R), .COLUMN_NUM(C), .M_END_BITWIDTH(8),
                   .LEN_BITWIDTH(8), .CNT_BITWIDTH(20)) dut (
    .clk(clk), .resetn(resetn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_m_end(cfg_m_end), .cfg_stream_len(cfg_stream_len), .abort(abort),
    .busy(busy), .done(done), .out_valid(out_valid), .out_row(out_row),
    .vector_weight_reg_en(w_en), .vector_weight_reg_r0w1(w_rw),
    .vector_input_reg_en(i_en), .vector_input_reg_r0w1(i_rw),
    .vector_rand_num_reg_en(r_en), .vector_rand_num_reg_r0w1(r_rw),
    .vector_output_num_reg_en(o_en), .vector_output_num_reg_r0w1(o_rw),
    .M_end(M_end));

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Model: a tile is fully described by its accept edge and (M, L).
  int   cyc = 0, acc_cyc = 0, m_k = 0, m_m = 0, m_l = 0;
  bit   m_act = 1'b0, mdl_ok = 1'b0;
  logic [7:0] m_mend = '0;

  function automatic int phase_of(int k, int m, int l);
    int t_len;
    t_len = m * l + R + C - 2;
    if (m == 0 || l == 0) return (k == 1) ? PH_DONE : PH_IDLE;
    if (k <= R)                 return PH_WLOAD;
    if (k <= R + t_len)         return PH_COMP;
    if (k <= 2 * R + t_len)     return PH_DRAIN;
    if (k == 2 * R + t_len + 1) return PH_DONE;
    return PH_IDLE;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!resetn) begin
      m_act  <= 1'b0;
      m_mend <= '0;
      mdl_ok <= 1'b1;
    end else if (m_act && abort) begin
      m_act <= 1'b0;
    end else if (!m_act && cfg_valid) begin
      m_act   <= 1'b1;
      m_k     <= 1;
      m_m     <= int'(cfg_m_end);
      m_l     <= int'(cfg_stream_len);
      m_mend  <= cfg_m_end;
      acc_cyc <= cyc;
    end else if (m_act) begin
      m_k <= m_k + 1;
      if (phase_of(m_k + 1, m_m, m_l) == PH_IDLE) m_act <= 1'b0;
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-tile observations, offsets counted in cycles after the accept edge.
  int w_cnt, dr_cnt, done_cnt, any_en, done_off, pe00_f, pe00_l, pe33_f, pe33_l, rdy_off;

  task automatic clear_stats();
    w_cnt = 0; dr_cnt = 0; done_cnt = 0; any_en = 0; done_off = -1;
    pe00_f = -1; pe00_l = -1; pe33_f = -1; pe33_l = -1; rdy_off = -1;
  endtask

  task automatic compare_now();
    int ph, t, ml, t_len, off;
    logic [PE-1:0] a;
    ph = m_act ? phase_of(m_k, m_m, m_l) : PH_IDLE;
    ml = m_m * m_l;
    t_len = ml + R + C - 2;
    t = m_k - R - 1;
    a = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        if (ph == PH_COMP && r + c <= t && t < r + c + ml) a[r*C + c] = 1'b1;
    chk("cfg_ready", 64'(cfg_ready), 64'(ph == PH_IDLE));
    chk("busy", 64'(busy), 64'(ph != PH_IDLE));
    chk("done", 64'(done), 64'(ph == PH_DONE));
    chk("out_valid", 64'(out_valid), 64'(ph == PH_DRAIN));
    chk("out_row", 64'(out_row), (ph == PH_DRAIN) ? 64'(m_k - R - t_len - 1) : 64'd0);
    chk("weight_en", 64'(w_en), (ph == PH_WLOAD) ? 64'hFFFF : 64'd0);
    chk("weight_r0w1", 64'(w_rw), (ph == PH_WLOAD) ? 64'hFFFF : 64'd0);
    chk("input_en", 64'(i_en), 64'(a));
    chk("input_r0w1", 64'(i_rw), 64'(a));
    chk("rand_en", 64'(r_en), 64'(a));
    chk("rand_r0w1", 64'(r_rw), 64'(a));
    chk("output_en", 64'(o_en), (ph == PH_DRAIN) ? 64'hFFFF : 64'(a));
    chk("output_r0w1", 64'(o_rw), 64'(a));
    chk("M_end", 64'(M_end), 64'({R{m_mend}}));
    off = cyc - acc_cyc;
    if (w_en == 16'hFFFF) w_cnt++;
    if (out_valid) dr_cnt++;
    if (done) begin done_cnt++; done_off = off; end
    if (|{w_en, i_en, r_en, o_en, w_rw, i_rw, r_rw, o_rw}) any_en++;
    if (i_en[0])  begin if (pe00_f < 0) pe00_f = off; pe00_l = off; end
    if (i_en[15]) begin if (pe33_f < 0) pe33_f = off; pe33_l = off; end
    if (cfg_ready && cfg_valid && rdy_off < 0) rdy_off = off;
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      if (mdl_ok) compare_now();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(int m, int l);
    cfg_m_end = 8'(m);
    cfg_stream_len = 8'(l);
    cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; cfg_valid = 1'b0; abort = 1'b0; cfg_m_end = '0; cfg_stream_len = '0;
    clear_stats();
    step(3);
    resetn = 1'b1;
    chk("reset_ready", 64'(cfg_ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_mend", 64'(M_end), 64'd0);
    step(2);

    // M=2, L=4: WLOAD offsets 1-4, COMPUTE 5-18, DRAIN 19-22, done at 23.
    clear_stats();
    issue(2, 4);
    step(25);
    chk("t1_wload_cycles", 64'(w_cnt), 64'd4);
    chk("t1_pe00_first", 64'(pe00_f), 64'd5);
    chk("t1_pe00_last", 64'(pe00_l), 64'd12);
    chk("t1_pe33_first", 64'(pe33_f), 64'd11);
    chk("t1_pe33_last", 64'(pe33_l), 64'd18);
    chk("t1_drain_cycles", 64'(dr_cnt), 64'd4);
    chk("t1_done_offset", 64'(done_off), 64'd23);
    chk("t1_done_count", 64'(done_cnt), 64'd1);

    // Degenerate tiles: done right after accept, array untouched.
    clear_stats();
    issue(0, 5);
    step(4);
    chk("m0_any_en", 64'(any_en), 64'd0);
    chk("m0_done_offset", 64'(done_off), 64'd1);
    clear_stats();
    issue(3, 0);
    step(4);
    chk("l0_any_en", 64'(any_en), 64'd0);
    chk("l0_done_offset", 64'(done_off), 64'd1);

    // Abort during COMPUTE t=5 (offset 10).
    clear_stats();
    issue(2, 4);
    step(9);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(cfg_ready), 64'd1);
    chk("abort_mats", 64'({i_en, r_en, o_en, o_rw}), 64'd0);
    step(3);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    clear_stats();
    issue(1, 1);
    step(18);
    chk("post_abort_done_offset", 64'(done_off), 64'd16);
    chk("post_abort_done_count", 64'(done_cnt), 64'd1);

    // Reset during DRAIN (M=1, L=2 drains at offsets 13-16).
    clear_stats();
    issue(1, 2);
    step(13);
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    chk("rst_drain_mend", 64'(M_end), 64'd0);
    chk("rst_drain_ovalid", 64'(out_valid), 64'd0);
    chk("rst_drain_ready", 64'(cfg_ready), 64'd1);
    chk("rst_drain_oen", 64'(o_en), 64'd0);
    chk("rst_drain_seen", 64'(dr_cnt), 64'd2);
    chk("rst_drain_no_done", 64'(done_cnt), 64'd0);
    step(2);

    // cfg_valid held: M=3, L=2 finishes at offset 21; re-accept at offset 22.
    cfg_m_end = 8'd3; cfg_stream_len = 8'd2; cfg_valid = 1'b1;
    step(1);
    clear_stats();
    cfg_m_end = 8'd5; cfg_stream_len = 8'd1;
    step(21);
    chk("hold_done_offset", 64'(done_off), 64'd21);
    chk("hold_no_early_accept", 64'(rdy_off), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("hold_mend_kept", 64'(M_end), 64'h0303_0303);
    step(1);
    cfg_valid = 1'b0;
    chk("hold_second_accept", 64'(rdy_off), 64'd22);
    chk("hold_mend_new", 64'(M_end), 64'h0505_0505);
    step(22);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      cfg_valid      = ($urandom_range(0, 2) == 0);
      cfg_m_end      = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 8));
      cfg_stream_len = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
      abort          = ($urandom_range(0, 39) == 0);
      resetn         = ($urandom_range(0, 199) != 0);
      step(1);
    end
    resetn = 1'b1; abort = 1'b0; cfg_valid = 1'b0;
    step(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pe_array_sched.md
Name: pe_array_sched

Overview:
Sequencer for the unary systolic PE array. Accepts one tile command per handshake and runs four phases: weight load (shift down rows), skewed compute wavefront, output drain (shift up to top edge), done. Drives every per-PE register enable/direction matrix and the per-row M_end of the array. Sits between the tile-level GEMM controller and the PE array.

Parameters:
ROW_NUM, 8, array rows
COLUMN_NUM, 8, array columns
M_END_BITWIDTH, 8, width of per-row M_end / vector count
LEN_BITWIDTH, 8, width of unary stream length per element
CNT_BITWIDTH, 20, phase cycle counter width; must hold M_END max * LEN max + ROW_NUM + COLUMN_NUM

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
cfg_valid  in  1  tile command valid
cfg_ready  out  1  scheduler idle, command accepted when valid&ready
cfg_m_end  in  M_END_BITWIDTH  input vectors in tile (M)
cfg_stream_len  in  LEN_BITWIDTH  unary cycles per element (L)
abort  in  1  cancel current tile
busy  out  1  not IDLE
done  out  1  one-cycle pulse at tile completion
out_valid  out  1  b_output_stream valid this cycle (drain)
out_row  out  $clog2(ROW_NUM)  row index of the drained word
vector_weight_reg_en, vector_weight_reg_r0w1  out  ROW_NUM*COLUMN_NUM  packed [r][c]
vector_input_reg_en, vector_input_reg_r0w1  out  ROW_NUM*COLUMN_NUM  packed [r][c]
vector_rand_num_reg_en, vector_rand_num_reg_r0w1  out  ROW_NUM*COLUMN_NUM  packed [r][c]
vector_output_num_reg_en, vector_output_num_reg_r0w1  out  ROW_NUM*COLUMN_NUM  packed [r][c]
M_end  out  ROW_NUM*M_END_BITWIDTH  per-row vector count, packed [r]

Behaviour:
- All outputs registered. Reset (resetn=0 at posedge): state IDLE, counter 0, every enable/r0w1 matrix 0, M_end 0, busy 0, done 0, out_valid 0, out_row 0, cfg_ready 1 on the cycle after reset. Reset mid-tile discards the tile with no done.
- States: IDLE, WLOAD, COMPUTE, DRAIN, DONE.
- IDLE: cfg_ready=1. On cfg_valid: latch M, L. Write M_end[r]=M for all r. If M==0 or L==0, go to DONE (no array activity). Otherwise go to WLOAD with t=0.
- WLOAD: ROW_NUM cycles. weight_reg_en=all 1, weight_reg_r0w1=all 1. After the last cycle, weight_reg_en drops to 0 and the weights hold for the tile. Then go to COMPUTE with t=0.
- COMPUTE: T = M*L + ROW_NUM + COLUMN_NUM - 2 cycles, t=0..T-1. PE(r,c) is active when r+c <= t < r+c+M*L.
- In COMPUTE, active PEs get input_reg_en=1, input_reg_r0w1=1, rand_num_reg_en=1, rand_num_reg_r0w1=1, output_num_reg_en=1, output_num_reg_r0w1=1 (accumulate). Inactive PEs get 0 on all four pairs.
- Compute product M*L is formed once at accept and held in a register.
- DRAIN: ROW_NUM cycles. output_num_reg_en=all 1, output_num_reg_r0w1=all 0 (shift toward row 0 / top).
- In DRAIN, out_valid=1 every cycle and out_row counts 0..ROW_NUM-1. The first drain cycle presents row 0.
- DONE: done=1 for exactly one cycle, all enables 0, then IDLE. M_end holds its value until the next accept.
- cfg_ready=0 in all non-IDLE states. cfg_valid outside IDLE is ignored, not queued.
- abort, any non-IDLE state: next cycle all enables/r0w1 are 0, out_valid=0, state IDLE, no done. abort in IDLE is ignored. abort has priority over phase transitions in the same cycle.
- Counter saturates never: on the final cycle of a phase it reloads to 0.
- busy=1 in WLOAD/COMPUTE/DRAIN/DONE.

Test Plan:
- ROW=COL=4. Reset, then cfg M=2, L=4 -> WLOAD 4 cycles with all weight en=1; COMPUTE 14 cycles; PE(0,0) en on t=0..7, PE(3,3) en on t=6..13; DRAIN 4 cycles with out_row 0,1,2,3; done pulse exactly 4+14+4+1 cycles after accept.
- Sample each COMPUTE cycle of the M=2, L=4 tile -> per-PE input/rand/output enables match r+c <= t < r+c+8; r0w1=1 wherever en=1; all zeros elsewhere.
- cfg M=0, L=5 -> no enable ever asserted, done the cycle after accept; M=3, L=0 same.
- abort on COMPUTE t=5 -> next cycle all matrices 0, busy 0, cfg_ready 1, no done; a new cfg M=1, L=1 then completes normally.
- resetn=0 during DRAIN -> next cycle all outputs at reset values including M_end=0.
- cfg_valid held high through the tile -> only one accept; second accept on the first IDLE cycle after done; M_end updates only at accept.
